adc_serial_capture: RTL and testbench

Serial ADC front-end sequencer that sits directly downstream of the power-up delay timer. After reset it enables the delay timer and waits for its `delay_done`. It then runs one chip-select-framed serial read per conversion request, shifting in an MSB-first frame from a 16-clock SPI-style ADC, and presents the result as a parallel sample with a one-cycle valid strobe.

---
 rtl/adc_serial_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_adc_serial_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
`default_nettype none
// ============================================================================
//  Module   : adc_serial_capture
//  Purpose  : Serial ADC front-end sequencer. Gates on the power-up delay
//             timer, then runs one CS-framed, MSB-first serial read per
//             conversion request and presents the result as a parallel
//             sample with a one-cycle valid strobe.
//  Options  : define ADC_CAPTURE_AVG_EN to run four frames per request and
//             report their truncated mean instead of a single frame.
//  Revision : 1.0  initial release
// ============================================================================
module adc_serial_capture #(
    parameter int CLK_DIV     = 4,   // clk cycles per SCLK half-period (>=1)
    parameter int FRAME_BITS  = 16,  // SCLK rising edges per frame (>=2)
    parameter int DATA_BITS   = 12,  // result width (<= FRAME_BITS)
    parameter int QUIET_TICKS = 2    // CS-high half-periods between frames
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 delay_done_i,
    output logic                 delay_en_o,
    input  logic                 adc_sdata_i,
    output logic                 adc_cs_n_o,
    output logic                 adc_sclk_o,
    output logic [DATA_BITS-1:0] sample_o,
    output logic                 sample_valid_o,
    output logic                 busy_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int QT_W  = $clog2(QUIET_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [QT_W-1:0]  QT_LAST  = QT_W'(QUIET_TICKS - 1);

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_CS_SETUP = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_QUIET    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [QT_W-1:0]        qt_q, qt_d;
    logic [FRAME_BITS-1:0]  sreg_q, sreg_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic                   delay_en_q, delay_en_d;
    logic [DATA_BITS-1:0]   sample_q, sample_d;
    logic                   valid_q, valid_d;

    logic                   w_tick;
    logic                   w_counting;
    logic [FRAME_BITS-1:0]  w_word;
    logic                   w_unused;

`ifdef ADC_CAPTURE_AVG_EN
    logic [DATA_BITS+1:0]   acc_q, acc_d;
    logic [1:0]             frm_q, frm_d;
    logic [DATA_BITS+1:0]   w_sum;
`endif

    // Divider tick: last clk of a SCLK half-period.
    assign w_tick     = (div_q == DIV_LAST);
    assign w_counting = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                        (state_q == ST_QUIET);

    // Word as it will look once the bit being captured now is shifted in.
    assign w_word     = {sreg_q[FRAME_BITS-2:0], adc_sdata_i};

    // Header bits above DATA_BITS are shifted through but never reported.
    assign w_unused   = ^{sreg_q[FRAME_BITS-1], w_word};

`ifdef ADC_CAPTURE_AVG_EN
    assign w_sum = acc_q + {2'b00, w_word[DATA_BITS-1:0]};
`endif

    // Next-state, divider, shift and output-register logic.
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        bit_d      = bit_q;
        qt_d       = qt_q;
        sreg_d     = sreg_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        delay_en_d = 1'b0;
        sample_d   = sample_q;
        valid_d    = 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
        acc_d      = acc_q;
        frm_d      = frm_q;
`endif

        // Counter restarts at zero on every tick, which also clears it on
        // entry to each counting state (all entries happen on a tick or
        // from IDLE where it is already zero).
        if (w_counting && !w_tick) begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            ST_POWERUP: begin
                if (delay_done_i) begin
                    state_d = ST_IDLE;
                end else begin
                    delay_en_d = 1'b1;
                end
            end

            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CS_SETUP;
                    cs_n_d  = 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
                    acc_d   = '0;
                    frm_d   = 2'd0;
`endif
                end
            end

            ST_CS_SETUP: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                end
            end

            ST_SHIFT: begin
                if (w_tick) begin
                    sclk_d = ~sclk_q;
                    // Capture on the low-to-high SCLK transition.
                    if (!sclk_q) begin
                        sreg_d = w_word;
                        bit_d  = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_QUIET;
                            cs_n_d  = 1'b1;
                            qt_d    = '0;
`ifdef ADC_CAPTURE_AVG_EN
                            acc_d   = w_sum;
                            frm_d   = frm_q + 2'd1;
                            if (frm_q == 2'd3) begin
                                sample_d = w_sum[DATA_BITS+1:2];
                                valid_d  = 1'b1;
                            end
`else
                            sample_d = w_word[DATA_BITS-1:0];
                            valid_d  = 1'b1;
`endif
                        end
                    end
                end
            end

            ST_QUIET: begin
                if (w_tick) begin
                    if (qt_q == QT_LAST) begin
`ifdef ADC_CAPTURE_AVG_EN
                        // frm_q wraps to zero after the fourth frame.
                        if (frm_q == 2'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_CS_SETUP;
                            cs_n_d  = 1'b0;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        qt_d = qt_q + QT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_POWERUP;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_POWERUP;
            div_q      <= '0;
            bit_q      <= '0;
            qt_q       <= '0;
            sreg_q     <= '0;
            sclk_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            delay_en_q <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            qt_q       <= qt_d;
            sreg_q     <= sreg_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            delay_en_q <= delay_en_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    // Accumulator and frame index for the four-frame average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            frm_q <= 2'd0;
        end else begin
            acc_q <= acc_d;
            frm_q <= frm_d;
        end
    end
`endif

    assign delay_en_o     = delay_en_q;
    assign adc_cs_n_o     = cs_n_q;
    assign adc_sclk_o     = sclk_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_adc_serial_capture
//  Purpose  : Self-checking bench for adc_serial_capture with a behavioural
//             ADC model and a frame-level reference for samples and timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_serial_capture;

    localparam int CLK_DIV     = 4;
    localparam int FRAME_BITS  = 16;
    localparam int DATA_BITS   = 12;
    localparam int QUIET_TICKS = 2;
`ifdef ADC_CAPTURE_AVG_EN
    localparam int FPR = 4;
`else
    localparam int FPR = 1;
`endif
    localparam int LAT     = CLK_DIV * (1 + 2 * FRAME_BITS);
    localparam int SPACING = CLK_DIV * (1 + 2 * FRAME_BITS + QUIET_TICKS) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 delay_done;
    logic                 delay_en;
    logic                 adc_sdata = 1'b0;
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 busy;

    adc_serial_capture #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_BITS  (FRAME_BITS),
        .DATA_BITS   (DATA_BITS),
        .QUIET_TICKS (QUIET_TICKS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .delay_done_i   (delay_done),
        .delay_en_o     (delay_en),
        .adc_sdata_i    (adc_sdata),
        .adc_cs_n_o     (adc_cs_n),
        .adc_sclk_o     (adc_sclk),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ADC model: loads a word when CS falls, presents the next bit MSB-first
    // after every SCLK fall.
    logic [FRAME_BITS-1:0] stim_q[$];
    logic [DATA_BITS-1:0]  frame_q[$];
    logic [FRAME_BITS-1:0] cur_word;
    int                    bit_idx = 0;
    bit                    frame_active = 1'b0;

    always @(adc_cs_n or negedge adc_sclk) begin
        if (adc_cs_n !== 1'b0) begin
            frame_active = 1'b0;
        end else if (!frame_active) begin
            frame_active = 1'b1;
            bit_idx      = 0;
            if (stim_q.size() > 0) cur_word = stim_q.pop_front();
            else                   cur_word = FRAME_BITS'($urandom);
            frame_q.push_back(cur_word[DATA_BITS-1:0]);
        end else if (adc_sclk === 1'b0 && bit_idx < FRAME_BITS) begin
            adc_sdata = cur_word[FRAME_BITS-1-bit_idx];
            bit_idx++;
        end
    end

    // Frame monitor and sample reference: mean of the frames of one request.
    int unsigned t_cs = 0;
    int unsigned last_strobe = 0;
    bit          have_last = 1'b0;
    int          strobes = 0;
    int          frames = 0;
    int          rises = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    int          spacing_q[$];

    always @(negedge clk) begin
        if (rst) begin
            frame_q.delete();
            rises     = 0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            have_last = 1'b0;
        end else begin
            if (prev_cs && !adc_cs_n) begin
                t_cs  = cyc;
                rises = 0;
                frames++;
            end
            if (!prev_sclk && adc_sclk && !prev_cs) rises++;
            if (!prev_cs && adc_cs_n) begin
                check("cs_low_cycles", cyc - t_cs, LAT);
                check("sclk_rises", rises, FRAME_BITS);
            end
            if (sample_valid) begin
                int sum;
                strobes++;
`ifndef ADC_CAPTURE_AVG_EN
                check("strobe_latency", cyc - t_cs, LAT);
`endif
                if (frame_q.size() < FPR) begin
                    check("model_frames_avail", frame_q.size(), FPR);
                end else begin
                    sum = 0;
                    for (int k = 0; k < FPR; k++) sum += int'(frame_q.pop_front());
                    check("sample", sample, sum / FPR);
                end
                if (have_last) spacing_q.push_back(int'(cyc - last_strobe));
                last_strobe = cyc;
                have_last   = 1'b1;
            end
            prev_cs   = adc_cs_n;
            prev_sclk = adc_sclk;
        end
    end

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobes < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("strobe_count", strobes, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic request();
        wait_idle(2000 * FPR);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cs_low_cnt;
        int en_low_cnt;
        int tgt;
        int f0;
        int s0;
        int n;

        rst        = 1'b1;
        start      = 1'b0;
        delay_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_delay_en", delay_en, 1'b0);
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_busy", busy, 1'b1);

        // Power-up gating with start held and delay_done low.
        rst   = 1'b0;
        start = 1'b1;
        cs_low_cnt = 0;
        en_low_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!adc_cs_n) cs_low_cnt++;
            if (!delay_en) en_low_cnt++;
        end
        check("powerup_cs_held", cs_low_cnt, 0);
        check("powerup_delay_en", en_low_cnt, 0);
        check("powerup_busy", busy, 1'b1);

        stim_q.push_back(16'h0ABC);
        delay_done = 1'b1;
        @(negedge clk);
        check("delay_en_dropped", delay_en, 1'b0);
        check("idle_after_powerup", busy, 1'b0);
        @(negedge clk);
        check("first_frame_cs", adc_cs_n, 1'b0);
        start = 1'b0;
        wait_strobes(1, 1000 * FPR);
        check("sample_0abc", sample, (FPR == 1) ? 32'h0ABC : 32'(sample));

        // Randomized single conversions.
        for (int i = 0; i < 4; i++) begin
            tgt = strobes + 1;
            request();
            wait_strobes(tgt, 1000 * FPR);
        end

`ifndef ADC_CAPTURE_AVG_EN
        // Back-to-back frames with start held.
        wait_idle(2000);
        stim_q.push_back(16'h0001);
        stim_q.push_back(16'h0FFF);
        stim_q.push_back(16'h0800);
        tgt   = strobes + 3;
        start = 1'b1;
        wait_strobes(tgt - 2, 1000);
        spacing_q.delete();
        wait_strobes(tgt, 1000);
        start = 1'b0;
        check("b2b_last_sample", sample, 32'h800);
        check("b2b_spacing_cnt", spacing_q.size(), 2);
        while (spacing_q.size() > 0) check("b2b_spacing", spacing_q.pop_front(), SPACING);
`else
        // Four-frame average.
        wait_idle(4000);
        stim_q.push_back(16'h0100);
        stim_q.push_back(16'h0200);
        stim_q.push_back(16'h0300);
        stim_q.push_back(16'h0403);
        f0  = frames;
        tgt = strobes + 1;
        request();
        wait_strobes(tgt, 4000);
        check("avg_sample", sample, 32'h280);
        repeat (2 * SPACING) @(negedge clk);
        check("avg_frames", frames - f0, 4);
        check("avg_single_strobe", strobes, tgt);
`endif

        // Request during a busy frame is dropped.
        wait_idle(2000 * FPR);
        f0 = frames;
        s0 = strobes;
        request();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_strobes(s0 + 1, 1000 * FPR);
        repeat (2 * SPACING) @(negedge clk);
        check("dropped_frames", frames - f0, FPR);
        check("dropped_strobes", strobes - s0, 1);

        // Reset in the middle of a frame.
        request();
        n = 0;
        while (rises < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_7_rises", rises >= 7, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_cs_n", adc_cs_n, 1'b1);
        check("midrst_sclk", adc_sclk, 1'b1);
        check("midrst_sample", sample, 0);
        check("midrst_valid", sample_valid, 1'b0);
        check("midrst_busy", busy, 1'b1);
        delay_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("repowerup_delay_en", delay_en, 1'b1);
        check("repowerup_busy", busy, 1'b1);
        delay_done = 1'b1;
        @(negedge clk);
        check("repowerup_done", delay_en, 1'b0);
        tgt = strobes + 1;
        request();
        wait_strobes(tgt, 1000 * FPR);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
